// File: rtl/mult_pkg.sv
// Shared constants for the signed shift-add multiplier datapath.
package mult_pkg;
    localparam int WIDTH = 8;
endpackage

// File: rtl/mult_datapath_add_sub9.sv
// Ripple-carry adder/subtractor. When sub is set, b is inverted and the
// carry-in is 1, so the result is a - b.
module add_sub9
    import mult_pkg::*;
#(
    parameter int N = WIDTH + 1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] s
);

    logic [N-1:0] b_eff;
    logic [N-1:0] carry;

    assign b_eff    = b ^ {N{sub}};
    assign carry[0] = sub;

    // The carry out of the top bit is dropped, so the result wraps.
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i] = a[i] ^ b_eff[i] ^ carry[i];
        if (i < N - 1) begin : g_carry
            assign carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
        end
    end

endmodule

// File: rtl/mult_datapath.sv
// Register and adder datapath for the 8-bit signed shift-add multiplier:
// holds X, A and B, and performs the add/subtract and arithmetic shift steps.
module mult_datapath #(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ClearAX,
    input  logic             ClearB,
    input  logic             LoadAX,
    input  logic             LoadB,
    input  logic             Shift,
    input  logic             Add,
    input  logic             Sub,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             M
);

    logic             x_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   s_operand;
    logic [WIDTH:0]   sum;

    // With neither Add nor Sub the adder passes A through sign-extended.
    assign a_ext     = {a_reg[WIDTH-1], a_reg};
    assign s_operand = (Add || Sub) ? {S[WIDTH-1], S} : '0;

    add_sub9 #(.N(WIDTH + 1)) u_add_sub (
        .a   (a_ext),
        .b   (s_operand),
        .sub (Sub),
        .s   (sum)
    );

    // B's shift uses the pre-edge A[0], even when {X,A} clears or loads.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            x_reg <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            if (ClearAX) begin
                x_reg <= 1'b0;
                a_reg <= '0;
            end else if (LoadAX) begin
                {x_reg, a_reg} <= sum;
            end else if (Shift) begin
                a_reg <= {x_reg, a_reg[WIDTH-1:1]};
            end

            if (ClearB) begin
                b_reg <= '0;
            end else if (LoadB) begin
                b_reg <= S;
            end else if (Shift) begin
                b_reg <= {a_reg[0], b_reg[WIDTH-1:1]};
            end
        end
    end

    assign Aval = a_reg;
    assign Bval = b_reg;
    assign X    = x_reg;
    assign M    = b_reg[0];

endmodule

// File: tb/tb_mult_datapath.sv
// Directed self-checking bench for mult_datapath: reset, load, full multiplies,
// adder wrap and the control-input priority rules.
module tb_mult_datapath;

    logic       Clk;
    logic       Reset;
    logic       ClearAX;
    logic       ClearB;
    logic       LoadAX;
    logic       LoadB;
    logic       Shift;
    logic       Add;
    logic       Sub;
    logic [7:0] S;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       X;
    logic       M;

    int pass_count  = 0;
    int check_count = 0;

    mult_datapath dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .ClearAX (ClearAX),
        .ClearB  (ClearB),
        .LoadAX  (LoadAX),
        .LoadB   (LoadB),
        .Shift   (Shift),
        .Add     (Add),
        .Sub     (Sub),
        .S       (S),
        .Aval    (Aval),
        .Bval    (Bval),
        .X       (X),
        .M       (M)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic cycle();
        @(posedge Clk);
        #1;
        Reset   = 1'b0;
        ClearAX = 1'b0;
        ClearB  = 1'b0;
        LoadAX  = 1'b0;
        LoadB   = 1'b0;
        Shift   = 1'b0;
        Add     = 1'b0;
        Sub     = 1'b0;
    endtask

    task automatic clear_load(input logic [7:0] mplier);
        S = mplier; ClearAX = 1'b1; LoadB = 1'b1;
        cycle();
    endtask

    task automatic load_ax(input logic add_i, input logic sub_i, input logic [7:0] s_i);
        S = s_i; LoadAX = 1'b1; Add = add_i; Sub = sub_i;
        cycle();
    endtask

    task automatic multiply(input logic [7:0] mplier, input logic [7:0] mcand);
        clear_load(mplier);
        for (int i = 0; i < 8; i++) begin
            if (M) load_ax(i < 7, i == 7, mcand);
            Shift = 1'b1;
            cycle();
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        cycle();
        check_count++;
        if ({X, Aval, Bval, M} !== {1'b0, 8'h00, 8'h00, 1'b0})
            $display("[TB] FAIL power_on_reset: got X=%b A=%h B=%h M=%b, want 0/00/00/0", X, Aval, Bval, M);
        else pass_count++;

        // Build X=1 A=0x5A B=0xC3: 0x180 - 0x26 = 0x15A.
        clear_load(8'hC3);
        load_ax(1'b1, 1'b0, 8'h80);
        load_ax(1'b0, 1'b1, 8'h26);
        check_count++;
        if ({X, Aval, Bval} !== {1'b1, 8'h5A, 8'hC3})
            $display("[TB] FAIL preload: got X=%b A=%h B=%h, want 1/5a/c3", X, Aval, Bval);
        else pass_count++;

        Reset = 1'b1; LoadAX = 1'b1; Add = 1'b1; Shift = 1'b1; S = 8'h11;
        cycle();
        check_count++;
        if ({X, Aval, Bval, M} !== {1'b0, 8'h00, 8'h00, 1'b0})
            $display("[TB] FAIL mid_reset: got X=%b A=%h B=%h M=%b, want 0/00/00/0", X, Aval, Bval, M);
        else pass_count++;
    endtask

    task automatic test_load();
        load_ax(1'b1, 1'b0, 8'h44);
        clear_load(8'h03);
        check_count++;
        if ({X, Aval, Bval, M} !== {1'b0, 8'h00, 8'h03, 1'b1})
            $display("[TB] FAIL clear_load: got X=%b A=%h B=%h M=%b, want 0/00/03/1", X, Aval, Bval, M);
        else pass_count++;

        ClearB = 1'b1; LoadB = 1'b1; S = 8'hFF;
        cycle();
        check_count++;
        if ({Bval, M} !== {8'h00, 1'b0})
            $display("[TB] FAIL clearb_priority: got B=%h M=%b, want 00/0", Bval, M);
        else pass_count++;
    endtask

    task automatic test_multiply();
        multiply(8'h03, 8'h05);
        check_count++;
        if ({X, Aval, Bval} !== {1'b0, 8'h00, 8'h0F})
            $display("[TB] FAIL mul_3x5: got X=%b A=%h B=%h, want 0/00/0f", X, Aval, Bval);
        else pass_count++;

        multiply(8'hFE, 8'h07);
        check_count++;
        if ({X, Aval, Bval} !== {1'b1, 8'hFF, 8'hF2})
            $display("[TB] FAIL mul_m2x7: got X=%b A=%h B=%h, want 1/ff/f2", X, Aval, Bval);
        else pass_count++;

        multiply(8'h80, 8'h80);
        check_count++;
        if ({Aval, Bval} !== 16'h4000)
            $display("[TB] FAIL mul_m128xm128: got A=%h B=%h, want 40/00", Aval, Bval);
        else pass_count++;
    endtask

    task automatic test_wrap();
        clear_load(8'h00);
        load_ax(1'b1, 1'b0, 8'h80);
        load_ax(1'b0, 1'b1, 8'h01);
        check_count++;
        if ({X, Aval} !== 9'h17F)
            $display("[TB] FAIL sub_wrap: got X=%b A=%h, want 1/7f", X, Aval);
        else pass_count++;

        Shift = 1'b1;
        cycle();
        check_count++;
        if ({X, Aval, Bval[7]} !== {1'b1, 8'hBF, 1'b1})
            $display("[TB] FAIL shift_after_wrap: got X=%b A=%h B7=%b, want 1/bf/1", X, Aval, Bval[7]);
        else pass_count++;

        // LoadAX alone re-sign-extends A: {A[7],A} = {1,0xBF}.
        load_ax(1'b0, 1'b0, 8'h55);
        check_count++;
        if ({X, Aval} !== 9'h1BF)
            $display("[TB] FAIL loadax_passthru: got X=%b A=%h, want 1/bf", X, Aval);
        else pass_count++;

        load_ax(1'b1, 1'b1, 8'h3F);
        check_count++;
        if ({X, Aval} !== 9'h180)
            $display("[TB] FAIL sub_over_add: got X=%b A=%h, want 1/80", X, Aval);
        else pass_count++;
    endtask

    task automatic test_priority();
        clear_load(8'h00);
        load_ax(1'b1, 1'b0, 8'h10);
        ClearAX = 1'b1; LoadAX = 1'b1; Add = 1'b1; S = 8'h22;
        cycle();
        check_count++;
        if ({X, Aval} !== 9'h000)
            $display("[TB] FAIL clearax_over_loadax: got X=%b A=%h, want 0/00", X, Aval);
        else pass_count++;

        LoadB = 1'b1; Shift = 1'b1; S = 8'h81;
        cycle();
        check_count++;
        if (Bval !== 8'h81)
            $display("[TB] FAIL loadb_over_shift: got B=%h, want 81", Bval);
        else pass_count++;

        load_ax(1'b1, 1'b0, 8'h03);
        ClearAX = 1'b1; Shift = 1'b1;
        cycle();
        check_count++;
        if ({X, Aval, Bval} !== {1'b0, 8'h00, 8'hC0})
            $display("[TB] FAIL clearax_with_shift: got X=%b A=%h B=%h, want 0/00/c0", X, Aval, Bval);
        else pass_count++;

        load_ax(1'b1, 1'b0, 8'h01);
        LoadAX = 1'b1; Add = 1'b1; S = 8'h20; Shift = 1'b1;
        cycle();
        check_count++;
        if ({X, Aval, Bval} !== {1'b0, 8'h21, 8'hE0})
            $display("[TB] FAIL loadax_with_shift: got X=%b A=%h B=%h, want 0/21/e0", X, Aval, Bval);
        else pass_count++;
    endtask

    initial begin
        Reset = 1'b0; ClearAX = 1'b0; ClearB = 1'b0; LoadAX = 1'b0;
        LoadB = 1'b0; Shift = 1'b0; Add = 1'b0; Sub = 1'b0; S = 8'h00;
        #2;
        test_reset();
        test_load();
        test_multiply();
        test_wrap();
        test_priority();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
